// File: rtl/mux_16to1_if.sv
// Bus bundle for the 16-to-1 bit selector: data word and index in,
// combinational and registered results out.
interface mux_16to1_if;
    logic [15:0] in;
    logic [3:0]  sel;
    logic        out;
    logic        out_q;
    logic [3:0]  sel_q;

    // Producer side: drives the data word and select, observes results.
    modport master (
        output in,
        output sel,
        input  out,
        input  out_q,
        input  sel_q
    );

    // Selector side.
    modport slave (
        input  in,
        input  sel,
        output out,
        output out_q,
        output sel_q
    );
endinterface

// File: rtl/mux_16to1.sv
// Single-bit 16-to-1 selector: out = in[sel], plus registered copies of the
// selected bit and the select index (1-cycle latency, synchronous reset).
// Build option: define MUX16TO1_OUT_REG_EN to drive `out` from the output
// register instead of the combinational path; the port list is unchanged.
module mux_16to1 (
    input  logic        clk,
    input  logic        rst,
    mux_16to1_if.slave  bus
);

    logic       sel_bit;
    logic       out_q;
    logic [3:0] sel_q;

    // Pick one bit of the data word; every 4-bit code is a valid index.
    always_comb begin
        sel_bit = bus.in[bus.sel];
    end

    // Capture the selected bit and its index every cycle; reset clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
            sel_q <= 4'h0;
        end else begin
            out_q <= sel_bit;
            sel_q <= bus.sel;
        end
    end

    assign bus.out_q = out_q;
    assign bus.sel_q = sel_q;

`ifdef MUX16TO1_OUT_REG_EN
    // Registered build: out shares the out_q flop.
    assign bus.out = out_q;
`else
    // Default build: zero-cycle path, independent of clk and rst.
    assign bus.out = sel_bit;
`endif

endmodule

// File: tb/tb_mux_16to1.sv
// Self-checking bench for mux_16to1: directed scenarios plus randomized
// traffic compared against a shift-and-mask reference model.
module tb_mux_16to1;

    logic clk;
    logic rst;
    logic clk_run;

    int checks;
    int errors;

    // Reference register state
    logic       m_out_q;
    logic [3:0] m_sel_q;

    mux_16to1_if bus ();

    mux_16to1 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock starts only once the clock-free combinational checks are done.
    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ref_bit(input logic [15:0] w, input logic [3:0] s);
        int unsigned v;
        v = (int'(w) / (1 << int'(s))) % 2;
        return (v != 0);
    endfunction

    // Expected value of `out` given the current inputs and model registers.
    function automatic logic exp_out();
`ifdef MUX16TO1_OUT_REG_EN
        return m_out_q;
`else
        return ref_bit(bus.in, bus.sel);
`endif
    endfunction

    // One clock edge: update the model with the pair present at the edge,
    // then compare all outputs shortly after.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_out_q = 1'b0;
            m_sel_q = 4'h0;
        end else begin
            m_out_q = ref_bit(bus.in, bus.sel);
            m_sel_q = bus.sel;
        end
        #1;
        check("out_q", 16'(bus.out_q), 16'(m_out_q));
        check("sel_q", 16'(bus.sel_q), 16'(m_sel_q));
        check("out_edge", 16'(bus.out), 16'(exp_out()));
    endtask

    logic [15:0] sweep_words [5];
    logic [3:0]  dir_sel [4];
    logic        dir_exp [4];

    initial begin
        checks  = 0;
        errors  = 0;
        clk_run = 1'b0;
        rst     = 1'b0;
        m_out_q = 1'b0;
        m_sel_q = 4'h0;
        bus.in  = 16'h0;
        bus.sel = 4'h0;

        sweep_words = '{16'h0001, 16'h8000, 16'hffff, 16'h0000, 16'ha5a5};
        dir_sel     = '{4'h0, 4'h1, 4'h6, 4'hc};
        dir_exp     = '{1'b0, 1'b1, 1'b0, 1'b1};

`ifndef MUX16TO1_OUT_REG_EN
        // Combinational select with no clock running.
        bus.in = 16'h3f0a;
        for (int i = 0; i < 4; i++) begin
            bus.sel = dir_sel[i];
            #5;
            check("comb_dir", 16'(bus.out), 16'(dir_exp[i]));
        end

        // Exhaustive sweep over selected words.
        for (int w = 0; w < 5; w++) begin
            for (int s = 0; s < 16; s++) begin
                bus.in  = sweep_words[w];
                bus.sel = 4'(s);
                #1;
                check("comb_sweep", 16'(bus.out), 16'(ref_bit(bus.in, bus.sel)));
            end
        end
`endif

        // Initial reset
        clk_run = 1'b1;
        rst     = 1'b1;
        bus.in  = 16'hffff;
        bus.sel = 4'h9;
        tick();
        check("rst_out_q", 16'(bus.out_q), 16'h0);
        check("rst_sel_q", 16'(bus.sel_q), 16'h0);
`ifdef MUX16TO1_OUT_REG_EN
        check("rst_out", 16'(bus.out), 16'h0);
`endif
        rst = 1'b0;

        // Registered path: sel 1 then 6 on consecutive edges.
        bus.in  = 16'h3f0a;
        bus.sel = 4'h1;
        tick();
        check("reg_out_q_1", 16'(bus.out_q), 16'h1);
        check("reg_sel_q_1", 16'(bus.sel_q), 16'h1);
        bus.sel = 4'h6;
        tick();
        check("reg_out_q_6", 16'(bus.out_q), 16'h0);
        check("reg_sel_q_6", 16'(bus.sel_q), 16'h6);

        // Reset mid-stream after out_q has been loaded with 1.
        bus.sel = 4'h1;
        tick();
        check("pre_rst_out_q", 16'(bus.out_q), 16'h1);
        rst    = 1'b1;
        bus.in = 16'hffff;
        tick();
        check("mid_rst_out_q", 16'(bus.out_q), 16'h0);
        check("mid_rst_sel_q", 16'(bus.sel_q), 16'h0);
        rst     = 1'b0;
        bus.sel = 4'h5;
        tick();
        check("post_rst_out_q", 16'(bus.out_q), 16'h1);
        check("post_rst_sel_q", 16'(bus.sel_q), 16'h5);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            bus.in  = 16'($urandom);
            bus.sel = 4'($urandom_range(0, 15));
            rst     = ($urandom_range(0, 15) == 0);
`ifndef MUX16TO1_OUT_REG_EN
            #1;
            check("rand_comb", 16'(bus.out), 16'(ref_bit(bus.in, bus.sel)));
`endif
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
